rv_control_unit: RTL and testbench

Multicycle control FSM that sequences the CPU datapath (register bank plus ALU) for an RV32I integer-ALU subset. It owns the program counter and presents it to the synchronous instruction memory, then latches the returned word into an instruction register. It decodes register fields, immediate and ALU operation, and issues a single-cycle register-bank write strobe per retired instruction. Illegal instructions trap; ECALL/EBREAK halt.

---
 rtl/rv_ctrl_pkg.sv | 32 +++
 rtl/rv_control_unit_decoder.sv | 72 +++++++
 rtl/rv_control_unit.sv | 103 ++++++++++
 tb/tb_rv_control_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared types and constants for the RV32I multicycle control unit.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    DECODE,
    EXECUTE,
    WRITEBACK,
    HALT,
    TRAP
  } ctrl_state_t;

  localparam logic [6:0]  OP_REG      = 7'b0110011;
  localparam logic [6:0]  OP_IMM      = 7'b0010011;
  localparam logic [6:0]  OP_SYSTEM   = 7'b1110011;
  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/rv_control_unit_decoder.sv
// Combinational RV32I integer-ALU decoder: IR -> ALU control, immediate, system/illegal flags.
module rv_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic [31:0] imm,
  output logic        is_system,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign imm    = {{20{ir[31]}}, ir[31:20]};

  always_comb begin
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    is_system   = 1'b0;
    illegal     = 1'b0;
    case (opcode)
      OP_REG: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  alu_op = ALU_ADD;
            3'b111:  alu_op = ALU_AND;
            3'b110:  alu_op = ALU_OR;
            3'b100:  alu_op = ALU_XOR;
            3'b001:  alu_op = ALU_SLL;
            3'b101:  alu_op = ALU_SRL;
            3'b010:  alu_op = ALU_SLT;
            default: illegal = 1'b1;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          alu_op = ALU_SUB;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_IMM: begin
        alu_src_imm = 1'b1;
        case (funct3)
          3'b000:  alu_op = ALU_ADD;
          3'b111:  alu_op = ALU_AND;
          3'b110:  alu_op = ALU_OR;
          3'b100:  alu_op = ALU_XOR;
          3'b010:  alu_op = ALU_SLT;
          3'b001:  if (funct7 == 7'b0) alu_op = ALU_SLL; else illegal = 1'b1;
          3'b101:  if (funct7 == 7'b0) alu_op = ALU_SRL; else illegal = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OP_SYSTEM: begin
        if (ir == INSN_ECALL || ir == INSN_EBREAK) is_system = 1'b1;
        else illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    // Rejected encodings present neutral controls to the datapath.
    if (illegal) begin
      alu_op      = ALU_ADD;
      alu_src_imm = 1'b0;
    end
  end

endmodule

// File: rtl/rv_control_unit.sv
// Multicycle control FSM for an RV32I integer-ALU subset.
// Optional retired-instruction counter enabled by defining RV_RETIRE_CNT_EN.
module rv_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic [31:0] imm,
  output logic        reg_write,
  output logic        halted,
  output logic        trap,
  output logic [31:0] retired
);

  localparam logic [1:0] WAIT_LAST = 2'(IMEM_LATENCY - 1);

  ctrl_state_t state, state_next;
  logic [31:0] ir;
  logic [1:0]  wait_cnt;
  logic        dec_system;
  logic        dec_illegal;

  rv_decoder u_decoder (
    .ir          (ir),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .imm         (imm),
    .is_system   (dec_system),
    .illegal     (dec_illegal)
  );

  assign imem_addr = pc;
  assign rs1       = ir[19:15];
  assign rs2       = ir[24:20];
  assign rd        = ir[11:7];
  assign halted    = (state == HALT);
  assign trap      = (state == TRAP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      ir       <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == FETCH) wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 2'd1;
      if (state == DECODE) ir <= imem_rdata;
      if (state == WRITEBACK) pc <= pc + 32'd4;
    end
  end

  always_comb begin
    state_next = state;
    reg_write  = 1'b0;
    case (state)
      IDLE:      if (run) state_next = FETCH;
      FETCH:     state_next = WAIT;
      WAIT:      if (wait_cnt == WAIT_LAST) state_next = DECODE;
      DECODE:    state_next = EXECUTE;
      EXECUTE: begin
        if (dec_illegal)     state_next = TRAP;
        else if (dec_system) state_next = HALT;
        else                 state_next = WRITEBACK;
      end
      WRITEBACK: begin
        // x0 is hardwired zero, so writes to it are suppressed here.
        reg_write  = (ir[11:7] != 5'd0);
        state_next = run ? FETCH : IDLE;
      end
      HALT:      state_next = HALT;
      TRAP:      state_next = TRAP;
      default:   state_next = IDLE;
    endcase
  end

`ifdef RV_RETIRE_CNT_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk) begin
    if (!rst_n) retired_q <= '0;
    else if (state == WRITEBACK) retired_q <= retired_q + 32'd1;
  end

  assign retired = retired_q;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_rv_control_unit.sv
// Self-checking bench for rv_control_unit: directed scenarios plus random words
// checked against a mask/match instruction table.
module tb_rv_control_unit;

`ifdef RV_RETIRE_CNT_EN
  localparam bit RET_EN = 1'b1;
`else
  localparam bit RET_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic run3 = 1'b0;

  logic [31:0] imem_addr, imem_rdata, pc, imm, retired;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  alu_op;
  logic        alu_src_imm, reg_write, halted, trap;

  logic [31:0] imem_addr3, imem_rdata3, pc3, imm3, retired3;
  logic [4:0]  rs1_3, rs2_3, rd3;
  logic [2:0]  alu_op3;
  logic        alu_src_imm3, reg_write3, halted3, trap3;

  rv_control_unit dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .imm(imm), .reg_write(reg_write), .halted(halted), .trap(trap), .retired(retired)
  );

  rv_control_unit #(.IMEM_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .run(run3),
    .imem_addr(imem_addr3), .imem_rdata(imem_rdata3), .pc(pc3),
    .rs1(rs1_3), .rs2(rs2_3), .rd(rd3), .alu_op(alu_op3), .alu_src_imm(alu_src_imm3),
    .imm(imm3), .reg_write(reg_write3), .halted(halted3), .trap(trap3), .retired(retired3)
  );

  // Synchronous instruction memories with 1- and 3-cycle read latency.
  logic [31:0] mem  [0:63];
  logic [31:0] mem3 [0:63];
  logic [31:0] pipe1;
  logic [31:0] pipe3 [0:2];

  always @(posedge clk) begin
    pipe1    <= mem[imem_addr[7:2]];
    pipe3[0] <= mem3[imem_addr3[7:2]];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign imem_rdata  = pipe1;
  assign imem_rdata3 = pipe3[2];

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] mask;
    logic [31:0] match;
    logic [2:0]  op;
    logic        src;
  } pat_t;

  pat_t legal_pats[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [31:0] word);
    mem[idx] = word;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    run3  = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] exp_ret(input int n);
    return RET_EN ? 32'(n) : 32'd0;
  endfunction

  // Reference decode: kind 0 = legal ALU op, 1 = ECALL/EBREAK, 2 = illegal.
  function automatic void ref_decode(input logic [31:0] w, output int kind,
                                     output logic [2:0] op, output logic src);
    kind = 2;
    op   = 3'd0;
    src  = 1'b0;
    foreach (legal_pats[i]) begin
      if ((w & legal_pats[i].mask) == legal_pats[i].match) begin
        kind = 0;
        op   = legal_pats[i].op;
        src  = legal_pats[i].src;
      end
    end
    if (w == 32'h0000_0073 || w == 32'h0010_0073) kind = 1;
  endfunction

  function automatic logic [31:0] gen_legal();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, legal_pats.size() - 1);
    return (w & ~legal_pats[k].mask) | legal_pats[k].match;
  endfunction

  function automatic logic [31:0] gen_word();
    logic [31:0] w, r;
    int sel;
    sel = $urandom_range(0, 3);
    w   = $urandom;
    r   = $urandom;
    case (sel)
      0: w = gen_legal();
      1: begin
        w[6:0] = r[0] ? 7'b0110011 : 7'b0010011;
        if (r[2:1] == 2'd0) w[31:25] = 7'h00;
        else if (r[2:1] == 2'd1) w[31:25] = 7'h20;
      end
      3: begin
        w = r[0] ? 32'h0000_0073 : 32'h0010_0073;
        if (r[3:1] == 3'd0) w[19:15] = r[8:4];
      end
      default: ;
    endcase
    return w;
  endfunction

  task automatic run_single(input logic [31:0] w);
    int kind;
    logic [2:0] op;
    logic src;
    do_reset();
    applyStimulus(0, w);
    run = 1'b1;
    repeat (4) tick();
    ref_decode(w, kind, op, src);
    checkOutput("rand.rs1", 32'(rs1), 32'(w[19:15]));
    checkOutput("rand.rs2", 32'(rs2), 32'(w[24:20]));
    checkOutput("rand.rd", 32'(rd), 32'(w[11:7]));
    checkOutput("rand.imm", imm, {{20{w[31]}}, w[31:20]});
    if (kind == 0) begin
      checkOutput("rand.alu_op", 32'(alu_op), 32'(op));
      checkOutput("rand.src", 32'(alu_src_imm), 32'(src));
    end
    tick();
    checkOutput("rand.reg_write", 32'(reg_write), 32'(kind == 0 && w[11:7] != 5'd0));
    checkOutput("rand.halted", 32'(halted), 32'(kind == 1));
    checkOutput("rand.trap", 32'(trap), 32'(kind == 2));
    tick();
    checkOutput("rand.pc", pc, (kind == 0) ? 32'd4 : 32'd0);
    checkOutput("rand.retired", retired, exp_ret((kind == 0) ? 1 : 0));
    run = 1'b0;
  endtask

  logic        seen_wr;
  logic        seen_addr4;
  logic [31:0] prog [0:15];
  int          kind_p;
  logic [2:0]  op_p;
  logic        src_p;

  initial begin
    legal_pats.push_back('{32'hFE00707F, 32'h00000033, 3'd0, 1'b0});
    legal_pats.push_back('{32'hFE00707F, 32'h40000033, 3'd1, 1'b0});
    legal_pats.push_back('{32'hFE00707F, 32'h00001033, 3'd5, 1'b0});
    legal_pats.push_back('{32'hFE00707F, 32'h00002033, 3'd7, 1'b0});
    legal_pats.push_back('{32'hFE00707F, 32'h00004033, 3'd4, 1'b0});
    legal_pats.push_back('{32'hFE00707F, 32'h00005033, 3'd6, 1'b0});
    legal_pats.push_back('{32'hFE00707F, 32'h00006033, 3'd3, 1'b0});
    legal_pats.push_back('{32'hFE00707F, 32'h00007033, 3'd2, 1'b0});
    legal_pats.push_back('{32'h0000707F, 32'h00000013, 3'd0, 1'b1});
    legal_pats.push_back('{32'h0000707F, 32'h00002013, 3'd7, 1'b1});
    legal_pats.push_back('{32'h0000707F, 32'h00004013, 3'd4, 1'b1});
    legal_pats.push_back('{32'h0000707F, 32'h00006013, 3'd3, 1'b1});
    legal_pats.push_back('{32'h0000707F, 32'h00007013, 3'd2, 1'b1});
    legal_pats.push_back('{32'hFE00707F, 32'h00001013, 3'd5, 1'b1});
    legal_pats.push_back('{32'hFE00707F, 32'h00005013, 3'd6, 1'b1});

    for (int i = 0; i < 64; i++) begin
      mem[i]  = 32'h0000_0013;
      mem3[i] = 32'h0000_0013;
    end

    do_reset();
    checkOutput("reset.pc", pc, 32'd0);
    checkOutput("reset.reg_write", 32'(reg_write), 32'd0);
    checkOutput("reset.halted", 32'(halted), 32'd0);
    checkOutput("reset.trap", 32'(trap), 32'd0);
    checkOutput("reset.retired", retired, 32'd0);
    checkOutput("reset.alu_op", 32'(alu_op), 32'd0);
    checkOutput("reset.src", 32'(alu_src_imm), 32'd0);
    checkOutput("reset.fields", {rs1, rs2, rd}, 32'd0);
    checkOutput("reset.imm", imm, 32'd0);
    checkOutput("reset.pc3", pc3, 32'd0);

    // ADDI, SUB, NOP then ECALL as a straight-line program.
    applyStimulus(0, 32'h00500093);
    applyStimulus(1, 32'h402081B3);
    applyStimulus(2, 32'h00000013);
    applyStimulus(3, 32'h00000073);
    run = 1'b1;
    repeat (4) tick();
    checkOutput("addi.alu_op", 32'(alu_op), 32'd0);
    checkOutput("addi.src", 32'(alu_src_imm), 32'd1);
    checkOutput("addi.imm", imm, 32'd5);
    checkOutput("addi.rd", 32'(rd), 32'd1);
    checkOutput("addi.no_early_write", 32'(reg_write), 32'd0);
    tick();
    checkOutput("addi.reg_write", 32'(reg_write), 32'd1);
    checkOutput("addi.pc_wb", pc, 32'd0);
    tick();
    checkOutput("addi.write_once", 32'(reg_write), 32'd0);
    checkOutput("addi.pc_next", pc, 32'd4);
    repeat (3) tick();
    checkOutput("sub.alu_op", 32'(alu_op), 32'd1);
    checkOutput("sub.src", 32'(alu_src_imm), 32'd0);
    checkOutput("sub.regs", {rs1, rs2, rd}, {5'd1, 5'd2, 5'd3});
    tick();
    checkOutput("sub.reg_write", 32'(reg_write), 32'd1);
    tick();
    checkOutput("sub.pc", pc, 32'd8);
    checkOutput("sub.write_once", 32'(reg_write), 32'd0);
    repeat (4) tick();
    checkOutput("nop.reg_write", 32'(reg_write), 32'd0);
    tick();
    checkOutput("nop.pc", pc, 32'd12);
    checkOutput("nop.retired", retired, exp_ret(3));
    repeat (4) tick();
    checkOutput("ecall.halted", 32'(halted), 32'd1);
    checkOutput("ecall.trap", 32'(trap), 32'd0);
    seen_wr = 1'b0;
    repeat (20) begin
      tick();
      if (reg_write) seen_wr = 1'b1;
    end
    checkOutput("ecall.still_halted", 32'(halted), 32'd1);
    checkOutput("ecall.pc_frozen", pc, 32'd12);
    checkOutput("ecall.no_write", 32'(seen_wr), 32'd0);
    checkOutput("ecall.retired", retired, exp_ret(3));
    do_reset();
    checkOutput("ecall.reset_halted", 32'(halted), 32'd0);
    checkOutput("ecall.reset_pc", pc, 32'd0);
    checkOutput("ecall.reset_retired", retired, 32'd0);

    // SRAI traps; the following word must never be fetched.
    applyStimulus(0, 32'h4010D093);
    applyStimulus(1, 32'hFFFFFFFF);
    run = 1'b1;
    repeat (4) tick();
    checkOutput("srai.trap_before", 32'(trap), 32'd0);
    tick();
    checkOutput("srai.trap", 32'(trap), 32'd1);
    seen_wr    = reg_write;
    seen_addr4 = 1'b0;
    repeat (10) begin
      tick();
      if (reg_write) seen_wr = 1'b1;
      if (imem_addr == 32'd4) seen_addr4 = 1'b1;
    end
    checkOutput("srai.pc_frozen", pc, 32'd0);
    checkOutput("srai.no_write", 32'(seen_wr), 32'd0);
    checkOutput("srai.no_fetch", 32'(seen_addr4), 32'd0);
    checkOutput("srai.trap_sticky", 32'(trap), 32'd1);
    checkOutput("srai.halted", 32'(halted), 32'd0);

    // Three-cycle memory, run dropped during EXECUTE then restored.
    do_reset();
    mem3[0] = 32'h00500093;
    mem3[1] = 32'h00A00113;
    run3 = 1'b1;
    repeat (6) tick();
    checkOutput("lat3.alu_op", 32'(alu_op3), 32'd0);
    checkOutput("lat3.imm", imm3, 32'd5);
    checkOutput("lat3.no_early_write", 32'(reg_write3), 32'd0);
    run3 = 1'b0;
    tick();
    checkOutput("lat3.reg_write", 32'(reg_write3), 32'd1);
    checkOutput("lat3.pc_wb", pc3, 32'd0);
    tick();
    checkOutput("lat3.pc_next", pc3, 32'd4);
    seen_wr = reg_write3;
    repeat (3) begin
      tick();
      if (reg_write3) seen_wr = 1'b1;
    end
    checkOutput("lat3.parked_pc", pc3, 32'd4);
    checkOutput("lat3.parked_no_write", 32'(seen_wr), 32'd0);
    run3 = 1'b1;
    repeat (6) tick();
    checkOutput("lat3.resume_rd", 32'(rd3), 32'd2);
    checkOutput("lat3.resume_imm", imm3, 32'd10);
    tick();
    checkOutput("lat3.resume_write", 32'(reg_write3), 32'd1);
    tick();
    checkOutput("lat3.resume_pc", pc3, 32'd8);
    checkOutput("lat3.retired", retired3, exp_ret(2));
    run3 = 1'b0;

    // Random single words, legal and illegal.
    for (int n = 0; n < 30; n++) run_single(gen_word());

    // Random legal program back to back.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      prog[i] = gen_legal();
      applyStimulus(i, prog[i]);
    end
    run = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      repeat (3) tick();
      ref_decode(prog[i], kind_p, op_p, src_p);
      checkOutput("prog.alu_op", 32'(alu_op), 32'(op_p));
      checkOutput("prog.src", 32'(alu_src_imm), 32'(src_p));
      checkOutput("prog.rd", 32'(rd), 32'(prog[i][11:7]));
      tick();
      checkOutput("prog.reg_write", 32'(reg_write), 32'(prog[i][11:7] != 5'd0));
      tick();
      checkOutput("prog.pc", pc, 32'(4 * (i + 1)));
    end
    checkOutput("prog.retired", retired, exp_ret(16));
    run = 1'b0;
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
